// File: rtl/csr_axil_bridge.sv
// AXI4-Lite slave to internal CSR bus bridge: one transaction in flight, word-aligned
// accesses only, SLVERR on misalignment, decode error or response timeout.
module csr_axil_bridge #(
   parameter int S_ADDR_WIDTH = 16,
   parameter int TIMEOUT_CYC  = 256
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [S_ADDR_WIDTH-1:0] s_awaddr,
   input  logic                    s_awvalid,
   output logic                    s_awready,
   input  logic [31:0]             s_wdata,
   input  logic                    s_wvalid,
   output logic                    s_wready,
   output logic [1:0]              s_bresp,
   output logic                    s_bvalid,
   input  logic                    s_bready,
   input  logic [S_ADDR_WIDTH-1:0] s_araddr,
   input  logic                    s_arvalid,
   output logic                    s_arready,
   output logic [31:0]             s_rdata,
   output logic [1:0]              s_rresp,
   output logic                    s_rvalid,
   input  logic                    s_rready,
   output logic                    csr_req_valid,
   output logic                    csr_req_write,
   output logic [31:0]             csr_req_addr,
   output logic [31:0]             csr_req_wdata,
   input  logic                    csr_rsp_valid,
   input  logic [31:0]             csr_rsp_rdata,
   input  logic                    csr_rsp_err
);

   typedef enum logic [2:0] {IDLE, REQ, WAIT, BRESP, RRESP} state_t;

   localparam int CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

   state_t                  state_reg, state_next;
   logic                    wr_prio_reg, wr_prio_next;
   logic                    write_reg, write_next;
   logic [S_ADDR_WIDTH-1:0] addr_reg, addr_next;
   logic [31:0]             wdata_reg, wdata_next;
   logic [31:0]             rdata_reg, rdata_next;
   logic                    err_reg, err_next;
   logic [CW-1:0]           cnt_reg, cnt_next;

   logic                    wr_elig, rd_elig, grant_wr, grant_rd;
   logic [S_ADDR_WIDTH-1:0] acc_addr;
   logic [CW-1:0]           cnt_inc;

   // A contested cycle goes to whichever side the priority flag favours.
   assign wr_elig  = s_awvalid && s_wvalid;
   assign rd_elig  = s_arvalid;
   assign grant_wr = (state_reg == IDLE) && wr_elig && (wr_prio_reg || !rd_elig);
   assign grant_rd = (state_reg == IDLE) && rd_elig && !(wr_elig && wr_prio_reg);
   assign acc_addr = grant_wr ? s_awaddr : s_araddr;
   assign cnt_inc  = cnt_reg + 1'b1;

   assign s_awready     = grant_wr;
   assign s_wready      = grant_wr;
   assign s_arready     = grant_rd;
   assign s_bvalid      = (state_reg == BRESP);
   assign s_rvalid      = (state_reg == RRESP);
   assign s_bresp       = (s_bvalid && err_reg) ? 2'b10 : 2'b00;
   assign s_rresp       = (s_rvalid && err_reg) ? 2'b10 : 2'b00;
   assign s_rdata       = rdata_reg;
   assign csr_req_valid = (state_reg == REQ);
   assign csr_req_write = write_reg;
   assign csr_req_addr  = 32'(addr_reg);
   assign csr_req_wdata = wdata_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg   <= IDLE;
         wr_prio_reg <= 1'b1;
         write_reg   <= 1'b0;
         addr_reg    <= '0;
         wdata_reg   <= '0;
         rdata_reg   <= '0;
         err_reg     <= 1'b0;
         cnt_reg     <= '0;
      end else begin
         state_reg   <= state_next;
         wr_prio_reg <= wr_prio_next;
         write_reg   <= write_next;
         addr_reg    <= addr_next;
         wdata_reg   <= wdata_next;
         rdata_reg   <= rdata_next;
         err_reg     <= err_next;
         cnt_reg     <= cnt_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      wr_prio_next = wr_prio_reg;
      write_next   = write_reg;
      addr_next    = addr_reg;
      wdata_next   = wdata_reg;
      rdata_next   = rdata_reg;
      err_next     = err_reg;
      cnt_next     = cnt_reg;
      case (state_reg)
         IDLE: begin
            if (grant_wr || grant_rd) begin
               write_next   = grant_wr;
               addr_next    = acc_addr;
               wdata_next   = grant_wr ? s_wdata : 32'h0;
               rdata_next   = 32'h0;
               wr_prio_next = !wr_prio_reg;
               // Misaligned accesses never reach the decode.
               if (acc_addr[1:0] != 2'b00) begin
                  err_next   = 1'b1;
                  state_next = grant_wr ? BRESP : RRESP;
               end else begin
                  err_next   = 1'b0;
                  state_next = REQ;
               end
            end
         end
         REQ: begin
            cnt_next   = '0;
            state_next = WAIT;
         end
         WAIT: begin
            if (csr_rsp_valid) begin
               rdata_next = write_reg ? 32'h0 : csr_rsp_rdata;
               err_next   = csr_rsp_err;
               state_next = write_reg ? BRESP : RRESP;
            end else if (cnt_inc == CNT_LAST) begin
               rdata_next = 32'h0;
               err_next   = 1'b1;
               state_next = write_reg ? BRESP : RRESP;
            end else begin
               cnt_next = cnt_inc;
            end
         end
         BRESP: if (s_bready) state_next = IDLE;
         RRESP: if (s_rready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

endmodule

// File: tb/tb_csr_axil_bridge.sv
// Self-checking bench for csr_axil_bridge: a decode model answers CSR requests and a
// scoreboard of expected requests/responses is filled as stimulus is driven.
module tb_csr_axil_bridge;

   localparam int AW = 16;
   localparam int TO = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [AW-1:0] s_awaddr = '0;
   logic          s_awvalid = 1'b0;
   logic          s_awready;
   logic [31:0]   s_wdata = '0;
   logic          s_wvalid = 1'b0;
   logic          s_wready;
   logic [1:0]    s_bresp;
   logic          s_bvalid;
   logic          s_bready = 1'b0;
   logic [AW-1:0] s_araddr = '0;
   logic          s_arvalid = 1'b0;
   logic          s_arready;
   logic [31:0]   s_rdata;
   logic [1:0]    s_rresp;
   logic          s_rvalid;
   logic          s_rready = 1'b0;
   logic          csr_req_valid;
   logic          csr_req_write;
   logic [31:0]   csr_req_addr;
   logic [31:0]   csr_req_wdata;
   logic          csr_rsp_valid = 1'b0;
   logic [31:0]   csr_rsp_rdata = '0;
   logic          csr_rsp_err = 1'b0;

   always #5 clk = ~clk;

   csr_axil_bridge #(.S_ADDR_WIDTH(AW), .TIMEOUT_CYC(TO)) dut (
      .clk(clk), .rst_n(rst_n),
      .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
      .s_wdata(s_wdata), .s_wvalid(s_wvalid), .s_wready(s_wready),
      .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
      .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
      .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
      .csr_req_valid(csr_req_valid), .csr_req_write(csr_req_write),
      .csr_req_addr(csr_req_addr), .csr_req_wdata(csr_req_wdata),
      .csr_rsp_valid(csr_rsp_valid), .csr_rsp_rdata(csr_rsp_rdata), .csr_rsp_err(csr_rsp_err)
   );

   typedef struct {logic wr; logic [31:0] addr; logic [31:0] wdata;} req_t;
   typedef struct {logic [1:0] resp; logic [31:0] rdata;} rsp_t;

   req_t exp_req_q[$];
   rsp_t exp_b_q[$];
   rsp_t exp_r_q[$];

   int pass_cnt = 0;
   int check_cnt = 0;
   int cyc = 0;
   int req_seen = 0;
   int last_req_cyc = 0;
   int dec_delay = 1;          // 0: decode never answers
   logic [31:0] dec_rdata = '0;
   logic        dec_err = 1'b0;
   int pend = 0;
   logic [31:0] pend_addr = '0;
   int wr_iss = 0;
   int rd_iss = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Decode model: answers dec_delay cycles after the request; read data = dec_rdata ^ addr.
   always @(negedge clk) begin : decode_model
      req_t e;
      logic [64:0] got_v, exp_v;
      csr_rsp_valid = 1'b0;
      csr_rsp_rdata = '0;
      csr_rsp_err   = 1'b0;
      if (!rst_n) pend = 0;
      if (pend > 0) begin
         pend = pend - 1;
         if (pend == 0) begin
            csr_rsp_valid = 1'b1;
            csr_rsp_rdata = dec_rdata ^ pend_addr;
            csr_rsp_err   = dec_err;
         end
      end
      if (rst_n && csr_req_valid) begin
         req_seen++;
         last_req_cyc = cyc;
         check_cnt++;
         if (exp_req_q.size() == 0) begin
            $display("FAIL req_unexpected: got wr=%0b addr=%h, required no request", csr_req_write, csr_req_addr);
         end else begin
            e = exp_req_q.pop_front();
            got_v = {csr_req_write, csr_req_addr, csr_req_write ? csr_req_wdata : 32'h0};
            exp_v = {e.wr, e.addr, e.wdata};
            if (got_v !== exp_v) $display("FAIL req_fields: got %h required %h", got_v, exp_v);
            else pass_cnt++;
         end
         if (dec_delay > 0) begin
            pend = dec_delay;
            pend_addr = csr_req_addr;
         end
      end
   end

   task automatic push_req(input logic wr, input logic [AW-1:0] addr, input logic [31:0] wdata);
      req_t e;
      e.wr = wr; e.addr = 32'(addr); e.wdata = wr ? wdata : 32'h0;
      exp_req_q.push_back(e);
   endtask

   task automatic push_rsp(input logic wr, input logic [1:0] resp, input logic [31:0] rdata);
      rsp_t e;
      e.resp = resp; e.rdata = rdata;
      if (wr) exp_b_q.push_back(e);
      else exp_r_q.push_back(e);
   endtask

   // Drives one transaction; starts and ends just after a rising edge.
   task automatic host_txn(input logic wr, input logic [AW-1:0] addr, input logic [31:0] data,
                           input int hold, output int acc_cyc, output int rsp_cyc,
                           output logic [1:0] resp, output logic [31:0] rdata,
                           output bit stable, output bit ok);
      bit got;
      ok = 1; stable = 1; acc_cyc = -1; rsp_cyc = -1; resp = '0; rdata = '0;
      if (wr) begin
         s_awaddr = addr; s_wdata = data; s_awvalid = 1'b1; s_wvalid = 1'b1;
      end else begin
         s_araddr = addr; s_arvalid = 1'b1;
      end
      got = 0;
      for (int n = 0; n < 50 && !got; n++) begin
         @(negedge clk);
         if (wr ? (s_awready && s_wready) : s_arready) begin
            got = 1;
            acc_cyc = cyc;
         end
         @(posedge clk);
         #1;
      end
      s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
      if (!got) begin ok = 0; return; end
      got = 0;
      for (int n = 0; n < 100 && !got; n++) begin
         @(negedge clk);
         if (wr ? s_bvalid : s_rvalid) begin
            got = 1;
            rsp_cyc = cyc;
            resp = wr ? s_bresp : s_rresp;
            rdata = s_rdata;
         end else begin
            @(posedge clk);
            #1;
         end
      end
      if (!got) begin ok = 0; return; end
      for (int n = 0; n < hold; n++) begin
         @(negedge clk);
         if (wr ? (!s_bvalid || s_bresp !== resp) : (!s_rvalid || s_rresp !== resp || s_rdata !== rdata))
            stable = 0;
      end
      @(posedge clk); #1;
      if (wr) s_bready = 1'b1; else s_rready = 1'b1;
      @(posedge clk); #1;
      s_bready = 1'b0; s_rready = 1'b0;
   endtask

   task automatic issue_w();
      s_awaddr = AW'(16'h0100 + wr_iss * 4);
      s_wdata  = 32'h1111_0000 + wr_iss;
      s_awvalid = 1'b1; s_wvalid = 1'b1;
      push_req(1'b1, s_awaddr, s_wdata);
      push_rsp(1'b1, 2'b00, 32'h0);
      wr_iss++;
   endtask

   task automatic issue_r();
      s_araddr = AW'(16'h0200 + rd_iss * 4);
      s_arvalid = 1'b1;
      push_req(1'b0, s_araddr, 32'h0);
      push_rsp(1'b0, 2'b00, dec_rdata ^ 32'(s_araddr));
      rd_iss++;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check_cnt++;
      if ({s_awready, s_wready, s_arready, s_bvalid, s_rvalid, csr_req_valid, csr_req_write} !== 7'b0)
         $display("FAIL reset_ctrl: got %b required 0000000", {s_awready, s_wready, s_arready, s_bvalid, s_rvalid, csr_req_valid, csr_req_write});
      else pass_cnt++;
      check_cnt++;
      if ({csr_req_addr, csr_req_wdata} !== 64'h0) $display("FAIL reset_req: got %h required 0", {csr_req_addr, csr_req_wdata});
      else pass_cnt++;
      check_cnt++;
      if ({s_bresp, s_rresp, s_rdata} !== 36'h0) $display("FAIL reset_resp: got %h required 0", {s_bresp, s_rresp, s_rdata});
      else pass_cnt++;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_write();
      int a, r; logic [1:0] resp; logic [31:0] rd; bit st, ok; rsp_t e; int seen0;
      seen0 = req_seen; dec_delay = 1; dec_err = 1'b0;
      push_req(1'b1, 16'h0010, 32'hDEAD_BEEF);
      push_rsp(1'b1, 2'b00, 32'h0);
      host_txn(1'b1, 16'h0010, 32'hDEAD_BEEF, 0, a, r, resp, rd, st, ok);
      e = exp_b_q.pop_front();
      check_cnt++;
      if (!ok) $display("FAIL write_done: got timeout required handshakes");
      else pass_cnt++;
      check_cnt++;
      if (resp !== e.resp) $display("FAIL write_bresp: got %b required %b", resp, e.resp);
      else pass_cnt++;
      check_cnt++;
      if (r - a !== 3) $display("FAIL write_latency: got %0d required 3", r - a);
      else pass_cnt++;
      check_cnt++;
      if (req_seen - seen0 !== 1) $display("FAIL write_req_count: got %0d required 1", req_seen - seen0);
      else pass_cnt++;
   endtask

   task automatic test_read_hold();
      int a, r; logic [1:0] resp; logic [31:0] rd; bit st, ok; rsp_t e;
      dec_delay = 1; dec_err = 1'b0; dec_rdata = 32'h1234_5678 ^ 32'h24;
      push_req(1'b0, 16'h0024, 32'h0);
      push_rsp(1'b0, 2'b00, 32'h1234_5678);
      host_txn(1'b0, 16'h0024, 32'h0, 5, a, r, resp, rd, st, ok);
      e = exp_r_q.pop_front();
      check_cnt++;
      if (!ok || resp !== e.resp || rd !== e.rdata)
         $display("FAIL read_data: got ok=%0b rresp=%b rdata=%h required rresp=%b rdata=%h", ok, resp, rd, e.resp, e.rdata);
      else pass_cnt++;
      check_cnt++;
      if (!st) $display("FAIL read_hold_stable: got unstable R channel required stable for 5 cycles");
      else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      int done, last_hs, seen0; bit aw_hs, ar_hs, b_hs, r_hs; rsp_t e; int grants[$]; logic [3:0] order;
      done = 0; last_hs = -1; seen0 = req_seen; wr_iss = 0; rd_iss = 0;
      dec_delay = 1; dec_err = 1'b0; dec_rdata = 32'hA5A5_0000;
      s_bready = 1'b1; s_rready = 1'b1;
      issue_w();
      issue_r();
      for (int n = 0; n < 200 && done < 4; n++) begin
         @(negedge clk);
         aw_hs = s_awvalid && s_awready;
         ar_hs = s_arvalid && s_arready;
         b_hs  = s_bvalid && s_bready;
         r_hs  = s_rvalid && s_rready;
         if (aw_hs || ar_hs) begin
            grants.push_back(aw_hs ? 1 : 0);
            if (last_hs >= 0) begin
               check_cnt++;
               if (cyc - last_hs !== 1) $display("FAIL b2b_gap: got %0d cycles required 1", cyc - last_hs);
               else pass_cnt++;
            end
         end
         if (b_hs) begin
            e = exp_b_q.pop_front();
            check_cnt++;
            if (s_bresp !== e.resp) $display("FAIL b2b_bresp: got %b required %b", s_bresp, e.resp);
            else pass_cnt++;
            done++; last_hs = cyc;
         end
         if (r_hs) begin
            e = exp_r_q.pop_front();
            check_cnt++;
            if (s_rresp !== e.resp || s_rdata !== e.rdata)
               $display("FAIL b2b_rdata: got %b/%h required %b/%h", s_rresp, s_rdata, e.resp, e.rdata);
            else pass_cnt++;
            done++; last_hs = cyc;
         end
         @(posedge clk); #1;
         if (aw_hs) begin s_awvalid = 1'b0; s_wvalid = 1'b0; end
         if (ar_hs) s_arvalid = 1'b0;
         if (b_hs && wr_iss < 2) issue_w();
         if (r_hs && rd_iss < 2) issue_r();
      end
      s_bready = 1'b0; s_rready = 1'b0; s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
      order = 4'b0;
      for (int i = 0; i < 4 && i < grants.size(); i++) order[3-i] = grants[i][0];
      check_cnt++;
      if (done !== 4 || grants.size() !== 4 || order !== 4'b1010)
         $display("FAIL b2b_order: got done=%0d grants=%0d order=%b required 4/4/1010", done, grants.size(), order);
      else pass_cnt++;
      check_cnt++;
      if (req_seen - seen0 !== 4) $display("FAIL b2b_req_count: got %0d required 4", req_seen - seen0);
      else pass_cnt++;
   endtask

   task automatic test_misaligned();
      int a, r, seen0; logic [1:0] resp; logic [31:0] rd; bit st, ok; rsp_t e;
      seen0 = req_seen; dec_delay = 1; dec_rdata = 32'hFFFF_FFFF;
      push_rsp(1'b0, 2'b10, 32'h0);
      host_txn(1'b0, 16'h0006, 32'h0, 0, a, r, resp, rd, st, ok);
      e = exp_r_q.pop_front();
      check_cnt++;
      if (!ok || resp !== e.resp || rd !== e.rdata)
         $display("FAIL misaligned_resp: got ok=%0b rresp=%b rdata=%h required rresp=%b rdata=%h", ok, resp, rd, e.resp, e.rdata);
      else pass_cnt++;
      check_cnt++;
      if (req_seen - seen0 !== 0) $display("FAIL misaligned_noreq: got %0d requests required 0", req_seen - seen0);
      else pass_cnt++;
   endtask

   task automatic test_decode_err();
      int a, r; logic [1:0] resp; logic [31:0] rd; bit st, ok; rsp_t e;
      dec_delay = 2; dec_err = 1'b1;
      push_req(1'b1, 16'h0F00, 32'h0BAD_0BAD);
      push_rsp(1'b1, 2'b10, 32'h0);
      host_txn(1'b1, 16'h0F00, 32'h0BAD_0BAD, 0, a, r, resp, rd, st, ok);
      e = exp_b_q.pop_front();
      check_cnt++;
      if (!ok || resp !== e.resp) $display("FAIL decode_err_bresp: got ok=%0b bresp=%b required %b", ok, resp, e.resp);
      else pass_cnt++;
      dec_err = 1'b0; dec_delay = 1;
   endtask

   task automatic test_timeout();
      int a, r; logic [1:0] resp; logic [31:0] rd; bit st, ok; rsp_t e;
      dec_delay = 20; dec_err = 1'b0;
      push_req(1'b1, 16'h0040, 32'hCAFE_F00D);
      push_rsp(1'b1, 2'b10, 32'h0);
      host_txn(1'b1, 16'h0040, 32'hCAFE_F00D, 8, a, r, resp, rd, st, ok);
      e = exp_b_q.pop_front();
      check_cnt++;
      if (!ok || resp !== e.resp) $display("FAIL timeout_bresp: got ok=%0b bresp=%b required %b", ok, resp, e.resp);
      else pass_cnt++;
      check_cnt++;
      if (r - last_req_cyc !== TO) $display("FAIL timeout_delay: got %0d cycles required %0d", r - last_req_cyc, TO);
      else pass_cnt++;
      check_cnt++;
      if (!st) $display("FAIL timeout_late_rsp: got B channel changed by late response required stable");
      else pass_cnt++;
      dec_delay = 1;
   endtask

   task automatic test_reset_mid();
      int a, r, seen0; logic [1:0] resp; logic [31:0] rd; bit st, ok, got; rsp_t e;
      dec_delay = 0; seen0 = req_seen;
      push_req(1'b0, 16'h0030, 32'h0);
      s_araddr = 16'h0030; s_arvalid = 1'b1;
      got = 0;
      for (int n = 0; n < 50 && !got; n++) begin
         @(negedge clk);
         if (s_arready) got = 1;
         @(posedge clk); #1;
      end
      s_arvalid = 1'b0;
      for (int n = 0; n < 20 && req_seen == seen0; n++) begin
         @(posedge clk); #1;
      end
      repeat (3) begin @(posedge clk); #1; end
      check_cnt++;
      if (!got || req_seen - seen0 !== 1) $display("FAIL rstmid_setup: got accept=%0b reqs=%0d required 1/1", got, req_seen - seen0);
      else pass_cnt++;
      rst_n = 1'b0;
      @(negedge clk);
      check_cnt++;
      if ({s_awready, s_wready, s_arready, s_bvalid, s_rvalid, csr_req_valid, csr_req_write, s_bresp, s_rresp, s_rdata} !== 43'h0)
         $display("FAIL rstmid_outputs: got %h required 0", {s_awready, s_wready, s_arready, s_bvalid, s_rvalid, csr_req_valid, csr_req_write, s_bresp, s_rresp, s_rdata});
      else pass_cnt++;
      @(posedge clk); #1;
      rst_n = 1'b1;
      dec_delay = 1; dec_rdata = 32'h0BEE_F000;
      push_req(1'b0, 16'h0034, 32'h0);
      push_rsp(1'b0, 2'b00, 32'h0BEE_F000 ^ 32'h34);
      @(posedge clk); #1;
      host_txn(1'b0, 16'h0034, 32'h0, 0, a, r, resp, rd, st, ok);
      e = exp_r_q.pop_front();
      check_cnt++;
      if (!ok || resp !== e.resp || rd !== e.rdata || r - a !== 3)
         $display("FAIL rstmid_next_read: got ok=%0b rresp=%b rdata=%h lat=%0d required %b/%h/3", ok, resp, rd, r - a, e.resp, e.rdata);
      else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_write();
      test_read_hold();
      test_back_to_back();
      test_misaligned();
      test_decode_err();
      test_timeout();
      test_reset_mid();
      repeat (3) @(posedge clk);
      check_cnt++;
      if (exp_req_q.size() + exp_b_q.size() + exp_r_q.size() !== 0)
         $display("FAIL scoreboard_drain: got %0d entries left required 0", exp_req_q.size() + exp_b_q.size() + exp_r_q.size());
      else pass_cnt++;
      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got simulation still running required completion");
      $fatal(1);
   end

endmodule
